// File: rtl/rx_frame_queue.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_queue
// Brief    : Frame-aware store-and-forward receive buffer. Frames are committed
//            on their last byte, bad frames are rewound and counted, committed
//            frames are replayed with their byte length presented up front.
//            Optional macro RX_FRAME_QUEUE_ERR_DROP_EN: drop frames whose last
//            beat carries in_err (otherwise in_err is ignored).
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_queue #(
    parameter int DEPTH        = 4096,
    parameter int LEN_DEPTH    = 16,
    parameter int MAX_FRAME    = 1518,
    parameter int PAUSE_THRESH = 1536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_err,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] out_len,
    output logic        frame_avail,
    output logic        almost_full,
    output logic [15:0] drop_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int LEN_W  = $clog2(LEN_DEPTH);
    localparam int LPTR_W = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // Storage
    logic [7:0]        ram [DEPTH];
    logic [15:0]       len_mem [LEN_DEPTH];
    logic [7:0]        ram_dout_q;

    // Write side state
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [15:0]       len_acc_q, len_acc_d;
    logic              drop_flag_q, drop_flag_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    // Length FIFO pointers
    logic [LPTR_W-1:0] len_wr_q, len_wr_d;
    logic [LPTR_W-1:0] len_rd_q, len_rd_d;
    logic              len_ne_q, len_ne_d;

    // Read side state
    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]       rem_q, rem_d;
    logic [15:0]       out_len_q, out_len_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              almost_full_q, almost_full_d;

    // Combinational helpers
    logic [PTR_W-1:0]  w_free_wr;
    logic [PTR_W-1:0]  w_free_now;
    logic              w_can_write;
    logic              w_ram_we;
    logic              w_len_push;
    logic              w_len_full;
    logic              w_len_not_empty;
    logic              w_len_ready;
    logic              w_frame_bad;
    logic              w_err_drop;
    logic [15:0]       w_len_head;
    logic [PTR_W-1:0]  w_rd_next;
    logic [ADDR_W-1:0] w_rd_addr;

`ifdef RX_FRAME_QUEUE_ERR_DROP_EN
    assign w_err_drop = in_err;
`else
    logic w_unused_err;
    assign w_unused_err = in_err;
    assign w_err_drop   = 1'b0;
`endif

    // Space released by the reader in this cycle is already usable by the writer.
    assign w_free_wr       = PTR_W'(DEPTH) - (wr_ptr_q - rd_ptr_d);
    assign w_free_now      = PTR_W'(DEPTH) - (wr_ptr_q - rd_ptr_q);
    assign w_len_full      = (len_wr_q - len_rd_q) == LPTR_W'(LEN_DEPTH);
    assign w_len_not_empty = (len_wr_q != len_rd_q);
    assign w_len_head      = len_mem[len_rd_q[LEN_W-1:0]];
    // A freshly pushed entry waits one cycle before the reader picks it up.
    assign w_len_ready     = len_ne_q & w_len_not_empty;
    assign len_ne_d        = w_len_not_empty;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_acc_d    = len_acc_q;
        drop_flag_d  = drop_flag_q;
        drop_cnt_d   = drop_cnt_q;
        len_wr_d     = len_wr_q;
        w_ram_we     = 1'b0;
        w_len_push   = 1'b0;
        w_frame_bad  = 1'b0;
        w_can_write  = (w_free_wr != '0) && (len_acc_q != 16'(MAX_FRAME));

        if (in_valid) begin
            if (w_can_write) begin
                w_ram_we  = 1'b1;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                len_acc_d = len_acc_q + 16'd1;
            end else begin
                drop_flag_d = 1'b1;
            end

            if (in_last) begin
                // A last byte that could not be stored also makes the frame incomplete.
                w_frame_bad = drop_flag_q | ~w_can_write | w_len_full | w_err_drop;
                if (w_frame_bad) begin
                    wr_ptr_d = commit_ptr_q;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else begin
                    commit_ptr_d = wr_ptr_q + PTR_W'(1);
                    w_len_push   = 1'b1;
                    len_wr_d     = len_wr_q + LPTR_W'(1);
                end
                len_acc_d   = '0;
                drop_flag_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        out_len_d   = out_len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        len_rd_d    = len_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (w_len_ready) begin
                    out_len_d = w_len_head;
                    rem_d     = w_len_head;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                out_data_d  = ram_dout_q;
                out_valid_d = 1'b1;
                out_last_d  = (rem_q == 16'd1);
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    rem_d    = rem_q - 16'd1;
                    if (out_last_q) begin
                        len_rd_d    = len_rd_q + LPTR_W'(1);
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_data_d = ram_dout_q;
                        out_last_d = (rem_q == 16'd2);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The RAM always reads one byte ahead of the next read pointer so that
    // back-to-back accepts never starve.
    assign w_rd_next = rd_ptr_d + PTR_W'(1);
    assign w_rd_addr = (state_q == ST_IDLE) ? rd_ptr_q[ADDR_W-1:0] : w_rd_next[ADDR_W-1:0];

    assign almost_full_d = {{(32-PTR_W){1'b0}}, w_free_now} < 32'(PAUSE_THRESH);

    // ------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram[wr_ptr_q[ADDR_W-1:0]] <= in_data;
        end
        ram_dout_q <= ram[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (w_len_push) begin
            len_mem[len_wr_q[LEN_W-1:0]] <= len_acc_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            len_acc_q     <= '0;
            drop_flag_q   <= 1'b0;
            drop_cnt_q    <= '0;
            len_wr_q      <= '0;
            len_rd_q      <= '0;
            len_ne_q      <= 1'b0;
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            rem_q         <= '0;
            out_len_q     <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            len_acc_q     <= len_acc_d;
            drop_flag_q   <= drop_flag_d;
            drop_cnt_q    <= drop_cnt_d;
            len_wr_q      <= len_wr_d;
            len_rd_q      <= len_rd_d;
            len_ne_q      <= len_ne_d;
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            rem_q         <= rem_d;
            out_len_q     <= out_len_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_len     = out_len_q;
    assign frame_avail = w_len_not_empty;
    assign almost_full = almost_full_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire
